audio_bit_sequencer: RTL and testbench
======================================

# audio_bit_sequencer

Parametrised serial-audio bit sequencer for the audio controller's serializer/deserializer path. It counts data bits within each left/right slot from pre-decoded bit-clock and LR-clock edge strobes. It supports I2S, left-justified and right-justified framing, configurable data and slot widths, and channel tracking. It generates per-bit shift enables, word-complete strobes and framing-error flags for the shift registers and FIFOs downstream.

## Interface
Parameters:
- `DATA_WIDTH`, default 24: audio bits per channel word; legal range 1..32.
- `SLOT_WIDTH`, default 32: bit clocks per LR half-period. Requires `SLOT_WIDTH >= DATA_WIDTH`; elaboration fails otherwise.
- `CNT_W`: local parameter, not overridable; equals `$clog2(SLOT_WIDTH+1)`.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high; priority over all other inputs.
- `mode` in 2: framing select. 0 = I2S, 1 = left-justified, 2 = right-justified, 3 = treated as I2S.
- `bit_clk_rising_edge` in 1: one-cycle strobe. Unused except as a lint-visible input.
- `bit_clk_falling_edge` in 1: one-cycle strobe marking a bit boundary.
- `left_right_clk_rising_edge` in 1: one-cycle strobe; starts a right-channel slot.
- `left_right_clk_falling_edge` in 1: one-cycle strobe; starts a left-channel slot.
- `counting` out 1: high while data bits of the current slot are active.
- `bit_index` out CNT_W: MSB-first index of the active data bit, running `DATA_WIDTH-1` down to 0.
- `channel` out 1: 0 = left, 1 = right; channel of the current slot.
- `shift_en` out 1: combinational; equals `counting & bit_clk_falling_edge & ~lr_edge`.
- `word_done` out 1: one-cycle pulse after the last data bit of a slot.
- `frame_error` out 1: one-cycle pulse when an LR edge arrives while a slot is still in DELAY or ACTIVE.

## Operation
- `lr_edge` = `left_right_clk_rising_edge | left_right_clk_falling_edge`.
- Reset values: state IDLE, `counting` 0, `bit_index` 0, `channel` 0, `word_done` 0, `frame_error` 0, `skip_cnt` 0.
- Per-mode delay, in falling edges skipped before the MSB:
  - I2S: 1.
  - Left-justified: 0.
  - Right-justified: `SLOT_WIDTH - DATA_WIDTH`.
- `mode` is sampled only in the `lr_edge` cycle. Mid-slot changes have no effect until the next LR edge.
- On `lr_edge`, from any state:
  - `channel` <= rising ? 1 : 0. If both strobes are set in the same cycle, rising wins.
  - `bit_index` <= `DATA_WIDTH-1`.
  - `skip_cnt` <= delay.
  - Next state is DELAY if delay > 0, else ACTIVE.
  - `frame_error` <= 1 if the current state is not IDLE.
- DELAY: on each `bit_clk_falling_edge`, if `skip_cnt == 1` go to ACTIVE, else `skip_cnt` decrements.
- ACTIVE (`counting` = 1): on each `bit_clk_falling_edge`:
  - if `bit_index == 0`: go to IDLE and set `word_done` <= 1;
  - else `bit_index` decrements.
- IDLE: falling edges are ignored and `bit_index` holds its value.
- `lr_edge` takes priority over a same-cycle `bit_clk_falling_edge`. That falling edge is neither counted nor flagged by `shift_en`.
- Every slot yields exactly `DATA_WIDTH` `shift_en` pulses, provided the slot is at least delay + `DATA_WIDTH` falling edges long.

## Timing
- LR edge at cycle t:
  - `counting` rises at t+1 when delay = 0;
  - otherwise it rises one cycle after the delay-th subsequent falling edge.
- `shift_en` has zero latency relative to `bit_clk_falling_edge`.
- Last-bit falling edge at cycle u: `counting` = 0 and `word_done` = 1 at u+1; `word_done` = 0 at u+2.
- `frame_error` is asserted at t+1 for a truncating LR edge at t. The truncated slot produces no `word_done`.
- Reset asserted mid-slot: all outputs take reset values on the next edge. No `word_done` or `frame_error` is issued for the aborted slot.

## Structure
- Package `audio_bit_seq_pkg` contains:
  - mode constants `MODE_I2S`, `MODE_LJ`, `MODE_RJ`;
  - state enum IDLE/DELAY/ACTIVE;
  - function `frame_delay(mode, DATA_WIDTH, SLOT_WIDTH)`.
- Single module with no sub-module.
- `skip_cnt` and `bit_index` stay separate registers so that `bit_index` is stable through DELAY.

## Test plan
- Left-justified, `DATA_WIDTH` = 24, `SLOT_WIDTH` = 32, 32 falling edges per slot: expect 24 `shift_en` pulses and `bit_index` 23..0. `word_done` follows the 24th edge; `channel` alternates 0/1.
- I2S, same parameters: first falling edge after the LR edge produces no `shift_en`; the 2nd..25th edges produce pulses; 25th → `word_done`.
- Right-justified, 16/32: first 16 falling edges are skipped; edges 17..32 produce pulses; `word_done` after the 32nd.
- LR edge after only 10 data bits: `frame_error` pulses once, new slot restarts at `bit_index` 23, no `word_done` for the truncated slot.
- LR edge in the same cycle as a falling edge: no `shift_en` in that cycle. `mode` changed mid-slot: current slot unaffected.
- Reset asserted in ACTIVE at `bit_index` 5: next cycle `counting` 0, `bit_index` 0, no strobes.

Source files
------------

// File: rtl/audio_bit_seq_pkg.sv
// Shared framing constants, sequencer state encoding and the per-mode
// MSB delay used by the serial-audio bit sequencer.
package audio_bit_seq_pkg;

    localparam logic [1:0] MODE_I2S = 2'd0;
    localparam logic [1:0] MODE_LJ  = 2'd1;
    localparam logic [1:0] MODE_RJ  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } seq_state_e;

    // Falling edges to skip after an LR edge before the MSB; the unused
    // fourth mode code behaves as I2S.
    function automatic int frame_delay(input logic [1:0] mode,
                                       input int data_width,
                                       input int slot_width);
        case (mode)
            MODE_LJ: return 0;
            MODE_RJ: return slot_width - data_width;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/audio_bit_sequencer.sv
// Counts data bits inside each LR slot from pre-decoded bit/LR clock edge
// strobes and produces shift enables, word-complete and framing-error pulses.
module audio_bit_sequencer
    import audio_bit_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    localparam int CNT_W = $clog2(SLOT_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             bit_clk_rising_edge,
    input  logic             bit_clk_falling_edge,
    input  logic             left_right_clk_rising_edge,
    input  logic             left_right_clk_falling_edge,
    output logic             counting,
    output logic [CNT_W-1:0] bit_index,
    output logic             channel,
    output logic             shift_en,
    output logic             word_done,
    output logic             frame_error
);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 32 || SLOT_WIDTH < DATA_WIDTH) begin : g_bad_params
        $error("audio_bit_sequencer: need 1 <= DATA_WIDTH <= 32 and SLOT_WIDTH >= DATA_WIDTH");
    end

    localparam logic [CNT_W-1:0] MSB_INDEX = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    seq_state_e       state;
    logic [CNT_W-1:0] skip_cnt;
    logic [CNT_W-1:0] slot_delay;
    logic             lr_edge;
    logic             unused_bit_clk_rise;

    assign unused_bit_clk_rise = bit_clk_rising_edge;
    assign lr_edge    = left_right_clk_rising_edge | left_right_clk_falling_edge;
    assign slot_delay = CNT_W'(frame_delay(mode, DATA_WIDTH, SLOT_WIDTH));

    // counting decodes straight from the state register, so it is glitch-free.
    assign counting = (state == ACTIVE);
    assign shift_en = counting & bit_clk_falling_edge & ~lr_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_index   <= '0;
            channel     <= 1'b0;
            word_done   <= 1'b0;
            frame_error <= 1'b0;
            skip_cnt    <= '0;
        end else begin
            word_done   <= 1'b0;
            frame_error <= 1'b0;
            if (lr_edge) begin
                // A new slot always restarts; a same-cycle falling edge is dropped.
                channel     <= left_right_clk_rising_edge;
                bit_index   <= MSB_INDEX;
                skip_cnt    <= slot_delay;
                state       <= (slot_delay != '0) ? DELAY : ACTIVE;
                frame_error <= (state != IDLE);
            end else if (bit_clk_falling_edge) begin
                case (state)
                    DELAY: begin
                        if (skip_cnt == ONE) begin
                            state <= ACTIVE;
                        end else begin
                            skip_cnt <= skip_cnt - ONE;
                        end
                    end
                    ACTIVE: begin
                        if (bit_index == '0) begin
                            state     <= IDLE;
                            word_done <= 1'b1;
                        end else begin
                            bit_index <= bit_index - ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_bit_sequencer.sv
// Randomized bench for two sequencer configurations (24/32 and 16/32) checked
// cycle by cycle against a falling-edge-count model of the framing rules.
module tb_audio_bit_sequencer;

    localparam int SW    = 32;
    localparam int CW    = $clog2(SW + 1);
    localparam int DW[2] = '{24, 16};

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic          bc_rise, bc_fall, lr_rise, lr_fall;
    logic          counting_o [2];
    logic [CW-1:0] bit_index_o[2];
    logic          channel_o  [2];
    logic          shift_en_o [2];
    logic          word_done_o[2];
    logic          frame_err_o[2];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: slot progress measured in falling edges since the LR edge.
    bit  open_m[2];
    int  k_m[2];
    int  d_m[2];
    bit  ch_m[2];
    bit  wd_m[2];
    bit  fe_m[2];
    logic [0:0] exp_q[$];
    bit  lr_next_rise = 1'b0;

    always #5 clk = ~clk;

    audio_bit_sequencer #(.DATA_WIDTH(24), .SLOT_WIDTH(SW)) dut0 (
        .clk(clk), .reset(reset), .mode(mode),
        .bit_clk_rising_edge(bc_rise), .bit_clk_falling_edge(bc_fall),
        .left_right_clk_rising_edge(lr_rise), .left_right_clk_falling_edge(lr_fall),
        .counting(counting_o[0]), .bit_index(bit_index_o[0]), .channel(channel_o[0]),
        .shift_en(shift_en_o[0]), .word_done(word_done_o[0]), .frame_error(frame_err_o[0])
    );

    audio_bit_sequencer #(.DATA_WIDTH(16), .SLOT_WIDTH(SW)) dut1 (
        .clk(clk), .reset(reset), .mode(mode),
        .bit_clk_rising_edge(bc_rise), .bit_clk_falling_edge(bc_fall),
        .left_right_clk_rising_edge(lr_rise), .left_right_clk_falling_edge(lr_fall),
        .counting(counting_o[1]), .bit_index(bit_index_o[1]), .channel(channel_o[1]),
        .shift_en(shift_en_o[1]), .word_done(word_done_o[1]), .frame_error(frame_err_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int ref_delay(input logic [1:0] m, input int dw);
        if (m == 2'd1) return 0;
        if (m == 2'd2) return SW - dw;
        return 1;
    endfunction

    function automatic bit in_data(input int i);
        return open_m[i] && k_m[i] >= d_m[i];
    endfunction

    // One clock: drive inputs, check shift_en combinationally, advance model, check registers.
    task automatic apply(input logic r, input logic [1:0] m, input logic lrr, input logic lrf,
                         input logic bfall);
        bit lr;
        int exp_idx;
        @(negedge clk);
        reset   = r;
        mode    = m;
        lr_rise = lrr;
        lr_fall = lrf;
        bc_fall = bfall;
        bc_rise = 1'($urandom_range(0, 1));
        lr      = lrr | lrf;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d.shift_en", i), 32'(shift_en_o[i]),
                  32'(!lr && bfall && in_data(i)));
            wd_m[i] = 1'b0;
            fe_m[i] = 1'b0;
            if (r) begin
                open_m[i] = 1'b0;
                k_m[i]    = 0;
                ch_m[i]   = 1'b0;
            end else if (lr) begin
                fe_m[i]   = open_m[i];
                open_m[i] = 1'b1;
                k_m[i]    = 0;
                d_m[i]    = ref_delay(m, DW[i]);
                ch_m[i]   = lrr;
            end else if (bfall && open_m[i]) begin
                k_m[i]++;
                if (k_m[i] == d_m[i] + DW[i]) begin
                    open_m[i] = 1'b0;
                    wd_m[i]   = 1'b1;
                    if (i == 0) exp_q.push_back(ch_m[i]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_idx = !open_m[i] ? 0 :
                      (k_m[i] >= d_m[i]) ? DW[i] - 1 - (k_m[i] - d_m[i]) : DW[i] - 1;
            check($sformatf("i%0d.counting", i), 32'(counting_o[i]), 32'(in_data(i)));
            check($sformatf("i%0d.bit_index", i), 32'(bit_index_o[i]), 32'(exp_idx));
            check($sformatf("i%0d.channel", i), 32'(channel_o[i]), 32'(ch_m[i]));
            check($sformatf("i%0d.word_done", i), 32'(word_done_o[i]), 32'(wd_m[i]));
            check($sformatf("i%0d.frame_error", i), 32'(frame_err_o[i]), 32'(fe_m[i]));
        end
        if (word_done_o[0]) begin
            if (exp_q.size() == 0) check("word_unexpected", 32'(1), 32'(0));
            else check("word_channel", 32'(channel_o[0]), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++)
            apply(1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    endtask

    // LR edge (alternating channel) followed by nfalls falling edges with random spacing;
    // mode is randomized on every non-LR cycle to show it is only sampled at the LR edge.
    task automatic run_slot(input logic [1:0] m, input int nfalls, input bit coincide);
        bit rise;
        rise         = lr_next_rise;
        lr_next_rise = !lr_next_rise;
        apply(1'b0, m, rise, !rise, coincide);
        for (int n = 0; n < nfalls; n++) begin
            idle_cycles($urandom_range(0, 2));
            apply(1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1; mode = 2'd0;
        bc_rise = 1'b0; bc_fall = 1'b0; lr_rise = 1'b0; lr_fall = 1'b0;
        apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
        idle_cycles(3);

        for (int s = 0; s < 4; s++) run_slot(2'd1, SW, 1'b0);
        for (int s = 0; s < 4; s++) run_slot(2'd0, SW, 1'b0);
        for (int s = 0; s < 4; s++) run_slot(2'd2, SW, 1'b0);
        idle_cycles(4);

        run_slot(2'd1, 10, 1'b0);
        run_slot(2'd1, SW, 1'b1);
        apply(1'b0, 2'd3, 1'b1, 1'b1, 1'b1);
        for (int n = 0; n < SW; n++) apply(1'b0, 2'd2, 1'b0, 1'b0, 1'b1);

        for (int s = 0; s < 30; s++)
            run_slot(2'($urandom_range(0, 3)), $urandom_range(4, 36), 1'($urandom_range(0, 1)));
        idle_cycles(3);

        // Abort a left-justified slot at bit_index 5 of the 24-bit instance.
        run_slot(2'd1, 18, 1'b0);
        apply(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        idle_cycles(2);
        run_slot(2'd0, SW, 1'b0);
        idle_cycles(4);

        check("words_outstanding", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
